// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and counter sizing.
package reset_sequencer_pkg;

  localparam logic [1:0] StateHold    = 2'd0;
  localparam logic [1:0] StateRelease = 2'd1;
  localparam logic [1:0] StateRun     = 2'd2;
  localparam logic [1:0] StateProgram = 2'd3;

  typedef enum logic [1:0] {
    StHold    = StateHold,
    StRelease = StateRelease,
    StRun     = StateRun,
    StProgram = StateProgram
  } state_e;

  // Bits needed for a counter whose largest value is max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Power-button synchroniser and debouncer. The debounced level is active-low like btn_n;
// press_pulse/release_pulse are high in the cycle before the level flips.
module btn_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CW = cnt_width(DEBOUNCE - 1);

  logic          sync1_q, sync2_q, level_q, flip;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      if (flip) level_q <= sync2_q;
    end
  end

  always_comb begin
    flip  = 1'b0;
    cnt_d = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) flip = 1'b1;
      else                            cnt_d = cnt_q + CW'(1);
    end
  end

  assign level         = level_q;
  assign press_pulse   = flip & level_q;
  assign release_pulse = flip & ~level_q;

endmodule

// File: rtl/reset_sequencer.sv
// Per-domain staggered reset release after PLL lock, with power-button warm reset and
// (when RESET_SEQUENCER_LONG_PRESS_PROG_EN is defined) long-press reconfiguration request.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned N_DOMAINS  = 3,
  parameter int unsigned COUNT      = 100,
  parameter int unsigned STAGGER    = 16,
  parameter int unsigned DEBOUNCE   = 1024,
  parameter int unsigned LONG_PRESS = 2**24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 force_rst_n,
  input  logic                 btn_n,
  output logic [N_DOMAINS-1:0] rst_n_out,
  output logic                 user_programn,
  output logic                 running
);

  localparam int unsigned HW = cnt_width(COUNT);
  localparam int unsigned SW = cnt_width(STAGGER - 1);

  logic                 force_s1_q, force_s2_q;
  state_e               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [SW-1:0]        stag_q, stag_d;
  logic [N_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                 running_q, running_d;
  logic                 btn_level, btn_press, btn_release;
  logic                 warm, long_press;

  btn_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_btn_debounce (
    .clk           (clk),
    .rst           (rst),
    .btn_n         (btn_n),
    .level         (btn_level),
    .press_pulse   (btn_press),
    .release_pulse (btn_release)
  );

`ifdef RESET_SEQUENCER_LONG_PRESS_PROG_EN
  localparam int unsigned PW = cnt_width(LONG_PRESS);

  logic [PW-1:0] press_q, press_d;
  logic          prog_n_q;

  // Press length in cycles since the debounced fall, saturating so it never wraps.
  always_comb begin
    press_d = press_q;
    if (btn_level || btn_press)        press_d = '0;
    else if (press_q != PW'(LONG_PRESS)) press_d = press_q + PW'(1);
  end

  assign long_press = ~btn_level & (press_q == PW'(LONG_PRESS - 1));
  assign warm       = btn_release & (press_q < PW'(LONG_PRESS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_q  <= '0;
      prog_n_q <= 1'b1;
    end else begin
      press_q <= press_d;
      if (long_press) prog_n_q <= 1'b0;
    end
  end

  assign user_programn = prog_n_q;
`else
  localparam int unsigned unused_long_press = LONG_PRESS;
  logic unused_btn;

  assign unused_btn    = btn_level ^ btn_press;
  assign long_press    = 1'b0;
  assign warm          = btn_release;
  assign user_programn = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      force_s1_q <= 1'b0;
      force_s2_q <= 1'b0;
      state_q    <= StHold;
      hold_q     <= '0;
      stag_q     <= '0;
      rst_n_q    <= '0;
      running_q  <= 1'b0;
    end else begin
      force_s1_q <= force_rst_n;
      force_s2_q <= force_s1_q;
      state_q    <= state_d;
      hold_q     <= hold_d;
      stag_q     <= stag_d;
      rst_n_q    <= rst_n_d;
      running_q  <= running_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stag_d    = stag_q;
    rst_n_d   = rst_n_q;
    running_d = running_q;
    if (long_press || state_q == StProgram) begin
      state_d   = StProgram;
      rst_n_d   = '0;
      running_d = 1'b0;
    end else if (!force_s2_q || warm) begin
      state_d   = StHold;
      hold_d    = '0;
      stag_d    = '0;
      rst_n_d   = '0;
      running_d = 1'b0;
    end else begin
      case (state_q)
        StHold: begin
          // Exit once COUNT lock-high cycles have been counted; domain 0 leaves reset here.
          if (hold_q == HW'(COUNT)) begin
            rst_n_d = N_DOMAINS'(1);
            stag_d  = '0;
            if (N_DOMAINS == 1) begin
              state_d   = StRun;
              running_d = 1'b1;
            end else begin
              state_d = StRelease;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        StRelease: begin
          if (stag_q == SW'(STAGGER - 1)) begin
            stag_d  = '0;
            rst_n_d = (rst_n_q << 1) | N_DOMAINS'(1);
            if (rst_n_d[N_DOMAINS-1]) begin
              state_d   = StRun;
              running_d = 1'b1;
            end
          end else begin
            stag_d = stag_q + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rst_n_out = rst_n_q;
  assign running   = running_q;

endmodule
